// File: rtl/danger_scheduler_pkg.sv
// Shared types and helpers for the obstacle scheduler.
// Type codes match the renderer's sprite selection.
package danger_scheduler_pkg;

  typedef enum logic [2:0] {
    LOW_BIRD     = 3'd0,
    HIGH_BIRD    = 3'd1,
    SMALL_CACTUS = 3'd2,
    MANY_CACTUS  = 3'd3,
    BIG_CACTUS   = 3'd4,
    NOTHING      = 3'd5
  } danger_type_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } sched_state_t;

  localparam int unsigned NUM_SLOTS = 3;
  // Galois mask for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Folds 5..7 back onto real obstacles so a spawn is never NOTHING.
  function automatic danger_type_t pick_type(input logic [2:0] r, input logic bird_en);
    logic [2:0] t;
    t = (r > 3'd4) ? r - 3'd3 : r;
    if (!bird_en && t < 3'd2) t = 3'd2;
    return danger_type_t'(t);
  endfunction

endpackage

// File: rtl/danger_scheduler_lfsr16.sv
// Free-running 16-bit Galois LFSR; steps every clock so player timing adds entropy.
module lfsr16
  import danger_scheduler_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= SEED;
    else     q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : '0);
  end

endmodule

// File: rtl/danger_scheduler.sv
// Spawns, scrolls and retires the three obstacle slots once per frame_tick while running.
// Slots are frozen in IDLE/HALT; entering RUN clears every slot and restarts the spawn gap.
module danger_scheduler
  import danger_scheduler_pkg::*;
#(
  parameter logic [9:0]  SPAWN_X  = 10'd720,
  parameter int unsigned MIN_GAP  = 40,
  parameter logic [5:0]  GAP_MASK = 6'h3F,
  parameter int unsigned INIT_GAP = 60,
  parameter bit          BIRD_EN  = 1'b1,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       crash,
  input  logic [2:0] speed,
  output logic       running,
  output logic [9:0] danger_pos1,
  output logic [9:0] danger_pos2,
  output logic [9:0] danger_pos3,
  output logic [2:0] danger_type1,
  output logic [2:0] danger_type2,
  output logic [2:0] danger_type3,
  output logic       danger_en1,
  output logic       danger_en2,
  output logic       danger_en3
);

  sched_state_t state;
  logic [15:0]  lfsr;
  logic         unused_lfsr;
  logic [2:0]   en_vec;
  logic [9:0]   step;
  logic         enter_run, tick_run, any_free, do_spawn;
  logic [1:0]   free_idx;
  logic [6:0]   gap, gap_dec, gap_reload;
  danger_type_t spawn_type;

  lfsr16 #(.SEED(SEED)) u_lfsr (.clk(clk), .rst(rst), .q(lfsr));

  assign unused_lfsr = ^lfsr[15:6];
  assign step        = (speed == 3'd0) ? 10'd1 : {7'd0, speed};
  assign enter_run   = (state != RUN) && start;
  // Crash wins over a coincident tick, and a tick on a state-change clock is dropped.
  assign tick_run    = (state == RUN) && !crash && frame_tick;
  assign gap_dec     = (gap != '0) ? gap - 7'd1 : '0;
  assign gap_reload  = 7'(MIN_GAP) + {1'b0, lfsr[5:0] & GAP_MASK};
  assign spawn_type  = pick_type(lfsr[2:0], BIRD_EN);
  assign do_spawn    = tick_run && any_free && (gap_dec == '0);

  // Occupancy is sampled before this tick's retires, so a retiring slot waits a tick.
  always_comb begin
    any_free = 1'b1;
    free_idx = 2'd0;
    if      (!en_vec[0]) free_idx = 2'd0;
    else if (!en_vec[1]) free_idx = 2'd1;
    else if (!en_vec[2]) free_idx = 2'd2;
    else                 any_free = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      running <= 1'b0;
      gap     <= 7'(INIT_GAP);
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) begin
            state   <= RUN;
            running <= 1'b1;
            gap     <= 7'(INIT_GAP);
          end
        end
        RUN: begin
          if (crash) begin
            state   <= HALT;
            running <= 1'b0;
          end else if (frame_tick) begin
            gap <= do_spawn ? gap_reload : gap_dec;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    logic [9:0]   pos;
    danger_type_t slot_type;
    logic         en;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pos       <= '0;
        slot_type <= NOTHING;
        en        <= 1'b0;
      end else if (enter_run) begin
        slot_type <= NOTHING;
        en        <= 1'b0;
      end else if (tick_run) begin
        if (en) begin
          if (pos <= step) begin
            pos       <= '0;
            slot_type <= NOTHING;
            en        <= 1'b0;
          end else begin
            pos <= pos - step;
          end
        end else if (do_spawn && free_idx == 2'(i)) begin
          pos       <= SPAWN_X;
          slot_type <= spawn_type;
          en        <= 1'b1;
        end
      end
    end

    assign en_vec[i] = en;
  end

  assign danger_pos1  = g_slot[0].pos;
  assign danger_pos2  = g_slot[1].pos;
  assign danger_pos3  = g_slot[2].pos;
  assign danger_type1 = g_slot[0].slot_type;
  assign danger_type2 = g_slot[1].slot_type;
  assign danger_type3 = g_slot[2].slot_type;
  assign danger_en1   = g_slot[0].en;
  assign danger_en2   = g_slot[1].en;
  assign danger_en3   = g_slot[2].en;

endmodule

// File: tb/tb_danger_scheduler.sv
// Scoreboarded bench for danger_scheduler: a reference model predicts every cycle,
// a second instance with birds disabled shares the stimulus.
module tb_danger_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0, start = 1'b0, crash = 1'b0;
  logic [2:0] speed = 3'd1;

  logic       running, danger_en1, danger_en2, danger_en3;
  logic [9:0] danger_pos1, danger_pos2, danger_pos3;
  logic [2:0] danger_type1, danger_type2, danger_type3;
  logic       nb_running, nb_en1, nb_en2, nb_en3;
  logic [9:0] nb_pos1, nb_pos2, nb_pos3;
  logic [2:0] nb_type1, nb_type2, nb_type3;

  danger_scheduler dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .crash(crash), .speed(speed),
    .running(running),
    .danger_pos1(danger_pos1), .danger_pos2(danger_pos2), .danger_pos3(danger_pos3),
    .danger_type1(danger_type1), .danger_type2(danger_type2), .danger_type3(danger_type3),
    .danger_en1(danger_en1), .danger_en2(danger_en2), .danger_en3(danger_en3)
  );

  danger_scheduler #(.BIRD_EN(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .crash(crash), .speed(speed),
    .running(nb_running),
    .danger_pos1(nb_pos1), .danger_pos2(nb_pos2), .danger_pos3(nb_pos3),
    .danger_type1(nb_type1), .danger_type2(nb_type2), .danger_type3(nb_type3),
    .danger_en1(nb_en1), .danger_en2(nb_en2), .danger_en3(nb_en3)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model
  logic [15:0] m_lfsr;
  int          m_state;  // 0 idle, 1 run, 2 halt
  logic        m_run;
  logic [9:0]  m_pos[3];
  logic [2:0]  m_type[3];
  logic [2:0]  m_type_nb[3];
  logic        m_en[3];
  int          m_gap;
  logic [85:0] sb_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  function automatic logic [2:0] exp_type(input logic [2:0] r, input bit birds);
    logic [2:0] t;
    case (r)
      3'd5:    t = 3'd2;
      3'd6:    t = 3'd3;
      3'd7:    t = 3'd4;
      default: t = r;
    endcase
    if (!birds && t < 3'd2) t = 3'd2;
    return t;
  endfunction

  function automatic logic [85:0] pack_model();
    return {m_run, m_en[0], m_en[1], m_en[2], m_pos[0], m_pos[1], m_pos[2],
            m_type[0], m_type[1], m_type[2],
            m_run, m_en[0], m_en[1], m_en[2], m_pos[0], m_pos[1], m_pos[2],
            m_type_nb[0], m_type_nb[1], m_type_nb[2]};
  endfunction

  function automatic logic [85:0] pack_dut();
    return {running, danger_en1, danger_en2, danger_en3, danger_pos1, danger_pos2, danger_pos3,
            danger_type1, danger_type2, danger_type3,
            nb_running, nb_en1, nb_en2, nb_en3, nb_pos1, nb_pos2, nb_pos3,
            nb_type1, nb_type2, nb_type3};
  endfunction

  function automatic logic dut_en(input int i);
    case (i)
      0:       return danger_en1;
      1:       return danger_en2;
      default: return danger_en3;
    endcase
  endfunction

  function automatic logic [9:0] dut_pos(input int i);
    case (i)
      0:       return danger_pos1;
      1:       return danger_pos2;
      default: return danger_pos3;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_run   = 1'b0;
    m_gap   = 60;
    for (int i = 0; i < 3; i++) begin
      m_pos[i] = '0; m_type[i] = 3'd5; m_type_nb[i] = 3'd5; m_en[i] = 1'b0;
    end
  endtask

  task automatic model_step(input logic st, input logic cr, input logic tk);
    int  stp;
    bit  fr[3];
    bit  spawned;
    if (m_state != 1) begin
      if (st) begin
        m_state = 1; m_run = 1'b1; m_gap = 60;
        for (int i = 0; i < 3; i++) begin
          m_en[i] = 1'b0; m_type[i] = 3'd5; m_type_nb[i] = 3'd5;
        end
      end
    end else if (cr) begin
      m_state = 2; m_run = 1'b0;
    end else if (tk) begin
      stp = (speed == 3'd0) ? 1 : int'(speed);
      for (int i = 0; i < 3; i++) fr[i] = !m_en[i];
      for (int i = 0; i < 3; i++) begin
        if (m_en[i]) begin
          if (int'(m_pos[i]) <= stp) begin
            m_en[i] = 1'b0; m_pos[i] = '0; m_type[i] = 3'd5; m_type_nb[i] = 3'd5;
          end else begin
            m_pos[i] = 10'(int'(m_pos[i]) - stp);
          end
        end
      end
      if (m_gap > 0) m_gap--;
      spawned = 0;
      if (m_gap == 0) begin
        for (int i = 0; i < 3; i++) begin
          if (fr[i] && !spawned) begin
            m_en[i] = 1'b1; m_pos[i] = 10'd720;
            m_type[i]    = exp_type(m_lfsr[2:0], 1'b1);
            m_type_nb[i] = exp_type(m_lfsr[2:0], 1'b0);
            spawned = 1;
          end
        end
      end
      if (spawned) m_gap = 40 + int'(m_lfsr[5:0]);
    end
  endtask

  task automatic cycle(input logic st, input logic cr, input logic tk);
    logic [85:0] exp_v, act_v;
    @(negedge clk);
    start = st; crash = cr; frame_tick = tk;
    model_step(st, cr, tk);
    sb_q.push_back(pack_model());
    @(posedge clk);
    #1;
    exp_v = sb_q.pop_front();
    act_v = pack_dut();
    n_tests++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL scoreboard t=%0t: got %h expected %h", $time, act_v, exp_v);
    end
  endtask

  task automatic tick();
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; crash = 1'b0; frame_tick = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (pack_dut() !== pack_model()) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected %h", pack_dut(), pack_model());
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 200; k++) tick();
    n_tests++;
    if ({running, danger_en1, danger_en2, danger_en3, danger_type1, danger_type2, danger_type3}
        !== {1'b0, 3'b000, 3'd5, 3'd5, 3'd5}) begin
      n_fail++;
      $display("FAIL idle_hold: got run=%b en=%b%b%b types=%0d/%0d/%0d expected 0 000 5/5/5",
               running, danger_en1, danger_en2, danger_en3, danger_type1, danger_type2, danger_type3);
    end
  endtask

  task automatic test_first_spawn();
    speed = 3'd2;
    cycle(1'b1, 1'b0, 1'b0);
    for (int k = 1; k < 60; k++) tick();
    n_tests++;
    if ({danger_en1, danger_en2, danger_en3} !== 3'b000) begin
      n_fail++;
      $display("FAIL early_spawn: got en=%b%b%b expected 000 after 59 ticks", danger_en1, danger_en2, danger_en3);
    end
    tick();
    n_tests++;
    if ({danger_en1, danger_pos1} !== {1'b1, 10'd720}) begin
      n_fail++;
      $display("FAIL spawn_tick60: got en1=%b pos1=%0d expected 1 720", danger_en1, danger_pos1);
    end
    tick();
    n_tests++;
    if (danger_pos1 !== 10'd718) begin
      n_fail++;
      $display("FAIL scroll_tick61: got pos1=%0d expected 718", danger_pos1);
    end
  endtask

  task automatic test_retire();
    speed = 3'd7;
    for (int k = 0; k < 200 && m_pos[0] >= 10'd10; k++) tick();
    if (m_pos[0] != 10'd3) begin
      speed = 3'(m_pos[0] - 10'd3);
      tick();
    end
    n_tests++;
    if ({danger_en1, danger_pos1} !== {1'b1, 10'd3}) begin
      n_fail++;
      $display("FAIL retire_setup: got en1=%b pos1=%0d expected 1 3", danger_en1, danger_pos1);
    end
    speed = 3'd4;
    tick();
    n_tests++;
    if ({danger_en1, danger_pos1, danger_type1} !== {1'b0, 10'd0, 3'd5}) begin
      n_fail++;
      $display("FAIL retire: got en1=%b pos1=%0d type1=%0d expected 0 0 5", danger_en1, danger_pos1, danger_type1);
    end
    for (int k = 0; k < 4; k++) tick();
  endtask

  task automatic test_all_busy();
    logic [2:0] pre;
    int         g, r;
    bit         found;
    do_reset();
    speed = 3'd1;
    cycle(1'b1, 1'b0, 1'b0);
    found = 0;
    r     = -1;
    for (int k = 0; k < 1200 && !found; k++) begin
      pre = {m_en[2], m_en[1], m_en[0]};
      g   = m_gap;
      tick();
      if (pre == 3'b111 && g == 0) begin
        for (int i = 0; i < 3; i++) if (!m_en[i] && r < 0) r = i;
        if (r >= 0) found = 1;
      end
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL busy_timeout: got no retire from a full slot set expected one within 1200 ticks");
    end else begin
      n_tests++;
      if (dut_en(r) !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_no_early_spawn: got en%0d=%b expected 0", r + 1, dut_en(r));
      end
      tick();
      n_tests++;
      if ({dut_en(r), dut_pos(r)} !== {1'b1, 10'd720}) begin
        n_fail++;
        $display("FAIL busy_respawn: got en%0d=%b pos=%0d expected 1 720", r + 1, dut_en(r), dut_pos(r));
      end
    end
  endtask

  task automatic test_crash();
    logic [29:0] snap;
    speed = 3'd3;
    for (int k = 0; k < 20; k++) tick();
    snap = {m_pos[0], m_pos[1], m_pos[2]};
    cycle(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 100; k++) begin
      cycle(1'b0, 1'b1, 1'b1);
      cycle(1'b0, 1'b1, 1'b0);
    end
    n_tests++;
    if ({running, danger_pos1, danger_pos2, danger_pos3} !== {1'b0, snap}) begin
      n_fail++;
      $display("FAIL crash_freeze: got run=%b pos=%0d/%0d/%0d expected 0 %0d/%0d/%0d", running,
               danger_pos1, danger_pos2, danger_pos3, snap[29:20], snap[19:10], snap[9:0]);
    end
    cycle(1'b1, 1'b0, 1'b0);
    n_tests++;
    if ({running, danger_en1, danger_en2, danger_en3} !== 4'b1000) begin
      n_fail++;
      $display("FAIL restart_clear: got run=%b en=%b%b%b expected 1 000", running, danger_en1, danger_en2, danger_en3);
    end
    for (int k = 1; k < 60; k++) tick();
    n_tests++;
    if ({danger_en1, danger_en2, danger_en3} !== 3'b000) begin
      n_fail++;
      $display("FAIL restart_gap_early: got en=%b%b%b expected 000", danger_en1, danger_en2, danger_en3);
    end
    tick();
    n_tests++;
    if ({danger_en1, danger_pos1} !== {1'b1, 10'd720}) begin
      n_fail++;
      $display("FAIL restart_gap60: got en1=%b pos1=%0d expected 1 720", danger_en1, danger_pos1);
    end
  endtask

  task automatic test_birds_and_speed0();
    int         birds_nb;
    logic [9:0] prev;
    birds_nb = 0;
    speed    = 3'd7;
    for (int k = 0; k < 400; k++) begin
      tick();
      if ((nb_en1 && nb_type1 < 3'd2) || (nb_en2 && nb_type2 < 3'd2) || (nb_en3 && nb_type3 < 3'd2))
        birds_nb++;
    end
    n_tests++;
    if (birds_nb !== 0) begin
      n_fail++;
      $display("FAIL no_birds: got %0d bird sightings expected 0", birds_nb);
    end
    speed = 3'd0;
    for (int k = 0; k < 3 && !m_en[0]; k++) tick();
    for (int k = 0; k < 200 && !m_en[0]; k++) tick();
    prev = m_pos[0];
    tick();
    n_tests++;
    if ({danger_en1, danger_pos1} !== {1'b1, prev - 10'd1}) begin
      n_fail++;
      $display("FAIL speed0_step: got en1=%b pos1=%0d expected 1 %0d", danger_en1, danger_pos1, prev - 10'd1);
    end
    for (int k = 0; k < 20; k++) tick();
  endtask

  initial begin
    #5ms;
    $display("FAIL global_timeout: got no finish expected finish before 5ms");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    test_reset();
    test_first_spawn();
    test_retire();
    test_all_busy();
    test_crash();
    test_birds_and_speed0();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
